// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: operand width,
// funct3 decodes and the controller state encoding.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    // funct3 values of the M-extension OP instructions
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) ||
               (f3 == MD_DIV)  || (f3 == MD_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_unit.sv
// One-bit-per-cycle datapath shared by multiply and divide.
// hi/lo form a 2*XLEN working register:
//   multiply: {hi,lo} is the shift-add accumulator, lo starts as the multiplier
//             and m holds the multiplicand; after XLEN steps {hi,lo} = product.
//   divide:   hi is the partial remainder, lo starts as the dividend and fills
//             with quotient bits from the right; m holds the divisor.
module muldiv_iter_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] init_lo,
    input  logic [XLEN-1:0] init_m,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] m_q;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Next-step arithmetic: conditional add for multiply, trial subtract for divide
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, m_q};
    end

    // Working registers: load on init, advance one bit per step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            m_q  <= '0;
        end else if (init) begin
            hi_q <= '0;
            lo_q <= init_lo;
            m_q  <= init_m;
        end else if (step) begin
            if (is_div) begin
                // Borrow out of the 33-bit subtract means the divisor did not fit
                if (!diff[XLEN]) begin
                    hi_q <= diff[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_q <= shifted[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_q <= add_sum[XLEN:1];
                lo_q <= {add_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Execute-stage sequencer for RV32M. Stalls the front of the pipe while the
// iterative unit runs on operand magnitudes, applies the sign fix-up, and
// presents the result with a one-cycle done pulse.
// Handshake: start_i is held by the pipeline for as long as stall_o is high;
// the result is valid only in the cycle done_o is high, and the start_i still
// present in that cycle belongs to the same instruction and is ignored.
import muldiv_pkg::*;

module ex_muldiv_ctrl #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic              a_neg_q;
    logic              b_neg_q;

    logic              accept;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic              unit_init;
    logic              unit_step;
    logic              unit_is_div;
    logic [XLEN-1:0]   unit_hi;
    logic [XLEN-1:0]   unit_lo;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    // Issue-side decode: sign flags, magnitudes and the fixed-result special cases
    always_comb begin
        accept  = (state_q == ST_IDLE) && start_i && !flush_i;
        a_neg   = a_is_signed(funct3_i) && op_a_i[XLEN-1];
        b_neg   = b_is_signed(funct3_i) && op_b_i[XLEN-1];
        a_mag   = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        b_mag   = b_neg ? (~op_b_i + 1'b1) : op_b_i;
        div_ovf = ((funct3_i == MD_DIV) || (funct3_i == MD_REM)) &&
                  (op_a_i == MIN_NEG) && (op_b_i == {XLEN{1'b1}});
        special = funct3_i[2] && ((op_b_i == '0) || div_ovf);
        if (op_b_i == '0) begin
            special_res = funct3_i[1] ? op_a_i : {XLEN{1'b1}};
        end else begin
            special_res = funct3_i[1] ? {XLEN{1'b0}} : MIN_NEG;
        end
        stall_o = accept || (state_q == ST_CALC) || (state_q == ST_SIGN);
    end

    // Iterative unit control: multiply loads the multiplier into lo, divide the dividend
    always_comb begin
        unit_init   = accept && !special;
        unit_step   = (state_q == ST_CALC) && !flush_i;
        unit_is_div = (state_q == ST_IDLE) ? funct3_i[2] : f3_q[2];
    end

    muldiv_iter_unit #(
        .XLEN(XLEN)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (unit_init),
        .step    (unit_step),
        .is_div  (unit_is_div),
        .init_lo (unit_is_div ? a_mag : b_mag),
        .init_m  (unit_is_div ? b_mag : a_mag),
        .hi_o    (unit_hi),
        .lo_o    (unit_lo)
    );

    // Sign fix-up and result selection applied in SIGN
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? (~{unit_hi, unit_lo} + 1'b1) : {unit_hi, unit_lo};
        quot_fix = (a_neg_q ^ b_neg_q) ? (~unit_lo + 1'b1) : unit_lo;
        rem_fix  = a_neg_q ? (~unit_hi + 1'b1) : unit_hi;
        case (f3_q)
            MD_MUL:                        final_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               final_res = quot_fix;
            default:                       final_res = rem_fix;
        endcase
    end

    // Sequencer FSM with registered done/result; flush outranks everything but reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_o  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        f3_q    <= funct3_i;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        cnt_q   <= '0;
                        if (special) begin
                            result_o <= special_res;
                            done_o   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    result_o <= final_res;
                    done_o   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    done_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed cases from the RV32M rules, flush and
// reset aborts, then randomized ops checked against a plain-arithmetic model.
module tb_ex_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int          checks_n;
    int          fail_n;
    logic [31:0] last_res;
    logic [31:0] exp_q[$];

    ex_muldiv_ctrl #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fail_n++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension results straight from signed/unsigned arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb);            return p[63:32]; end
            3'd2: begin p = 64'(sa * ub);            return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f3 < 3'd4) return 1'b0;
        if (b == 0) return 1'b1;
        return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one instruction and follow it cycle by cycle until it retires
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit special);
        int lat;
        lat = special ? 1 : 34;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            check($sformatf("stall f3=%0d c=%0d", f3, c), 32'(stall_o), 32'(c < lat));
            check($sformatf("done f3=%0d c=%0d", f3, c), 32'(done_o), 32'(c == lat));
            if (c == lat) begin
                check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result_o, exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        @(negedge clk);
        check($sformatf("retire_done f3=%0d", f3), 32'(done_o), 32'd0);
        check($sformatf("retire_stall f3=%0d", f3), 32'(stall_o), 32'd0);
        last_res = exp;
    endtask

    // Start an op and abort it in cycle k, by flush or by reset
    task automatic abort_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input int k, input bit use_reset);
        @(posedge clk); #1;
        start_i  = 1'b1;
        funct3_i = f3;
        op_a_i   = a;
        op_b_i   = b;
        for (int c = 0; c < k; c++) begin
            @(posedge clk); #1;
        end
        if (use_reset) rst_n = 1'b0;
        else flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        if (use_reset) last_res = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("abort_stall r=%0d c=%0d", use_reset, c), 32'(stall_o), 32'd0);
            check($sformatf("abort_done r=%0d c=%0d", use_reset, c), 32'(done_o), 32'd0);
            check($sformatf("abort_result r=%0d c=%0d", use_reset, c), result_o, last_res);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        checks_n = 0;
        fail_n   = 0;
        last_res = 32'h0;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        funct3_i = 3'd0;
        op_a_i   = 32'h0;
        op_b_i   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_result", result_o, 32'h0);

        // Directed multiply / divide
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);

        // Special cases
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);

        // Flush in cycle 10 of a DIV, then a MUL issued right after
        abort_op(3'd4, 32'd1000, 32'd3, 10, 1'b0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

        // Reset in cycle 20 of a MUL
        abort_op(3'd0, 32'd9, 32'd9, 20, 1'b1);
        run_op(3'd0, 32'd6, 32'd7, 32'd42, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(f3, a, b, ref_result(f3, a, b), is_special(f3, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

endmodule
